// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Memory-handshake state of the hazard controller.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ABORT    = 2'd2
  } hz_state_e;

  // EX-stage operand source selects.
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding: picks the youngest in-flight producer of each source register.
module forwarding_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_RegWrite,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_RegWrite,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  // EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] em_rd, input logic em_we,
                                         input logic [4:0] mw_rd, input logic mw_we);
    if (em_we && (em_rd != 5'd0) && (em_rd == rs)) begin
      return FWD_EXMEM;
    end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs)) begin
      return FWD_MEMWB;
    end
    return FWD_NONE;
  endfunction

  // Both operands resolved independently with the same rule.
  always_comb begin
    forward_a = fwd_sel(ex_rs1, exmem_rd, exmem_RegWrite, memwb_rd, memwb_RegWrite);
    forward_b = fwd_sel(ex_rs2, exmem_rd, exmem_RegWrite, memwb_rd, memwb_RegWrite);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes, load-use stall, branch flush,
// data-memory wait with timeout, and operand forwarding selects.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  idex_rd,
  input  logic        idex_MemRead,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_RegWrite,
  input  logic [4:0]  memwb_rd,
  input  logic        memwb_RegWrite,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        mem_error
);

  localparam logic [TMO_W-1:0] CntLast = TMO_W'(MEM_TIMEOUT - 1);

  hz_state_e        state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] cnt_inc;
  logic             mem_error_q, mem_error_d;
  logic             load_use;
  logic             freeze;
  logic             run_rules;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign cnt_inc  = cnt_q + TMO_W'(1);
  assign load_use = idex_MemRead && (idex_rd != 5'd0) &&
                    ((idex_rd == id_rs1) || (idex_rd == id_rs2));

  forwarding_unit u_fwd (
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .exmem_rd       (exmem_rd),
    .exmem_RegWrite (exmem_RegWrite),
    .memwb_rd       (memwb_rd),
    .memwb_RegWrite (memwb_RegWrite),
    .forward_a      (fwd_a_raw),
    .forward_b      (fwd_b_raw)
  );

  // Reset forces forward selects to the register file.
  assign forward_a = reset ? FWD_NONE : fwd_a_raw;
  assign forward_b = reset ? FWD_NONE : fwd_b_raw;
  assign mem_error = mem_error_q;

  // Next state and stage controls; reset overrides everything to a frozen, flushing pipeline.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_error_d = mem_error_q;
    freeze      = 1'b0;
    run_rules   = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;

    unique case (state_q)
      RUN: begin
        // The access that first misses is already a frozen cycle.
        if (mem_req && !mem_ready) begin
          state_d = MEM_WAIT;
          cnt_d   = '0;
          freeze  = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d   = RUN;
          cnt_d     = '0;
          run_rules = 1'b1;
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == CntLast) begin
            state_d = ABORT;
          end
        end
      end
      ABORT: begin
        // Drop the stuck EX/MEM access and let everything else advance.
        memwb_flush = 1'b1;
        mem_error_d = 1'b1;
        cnt_d       = '0;
        state_d     = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (run_rules) begin
      // A taken branch kills the dependent younger instruction, so no stall is needed.
      if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  // State, wait counter and sticky error register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counters; ifid_flush outside reset only comes from a taken branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (ifid_flush && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned MemTimeout = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, idex_rd, ex_rs1, ex_rs2, exmem_rd, memwb_rd;
  logic       idex_MemRead, exmem_RegWrite, memwb_RegWrite;
  logic       branch_taken, mem_req, mem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, memwb_flush, mem_error;
  logic [1:0] forward_a, forward_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: consecutive frozen cycles, pending abort cycle, sticky error.
  int m_waits = 0;
  bit m_abort = 1'b0;
  bit m_err   = 1'b0;

  hazard_ctrl #(.MEM_TIMEOUT(MemTimeout), .TMO_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .idex_rd        (idex_rd),
    .idex_MemRead   (idex_MemRead),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .exmem_rd       (exmem_rd),
    .exmem_RegWrite (exmem_RegWrite),
    .memwb_rd       (memwb_rd),
    .memwb_RegWrite (memwb_RegWrite),
    .branch_taken   (branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .memwb_flush    (memwb_flush),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .mem_error      (mem_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (exmem_RegWrite && exmem_rd != 0 && exmem_rd == rs) return 2'b10;
    if (memwb_RegWrite && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_frozen();
    return !mem_ready && (m_waits > 0 || mem_req);
  endfunction

  // {pc,ifid,idex,exmem,memwb enables, ifid/idex/memwb flushes, fwd a, fwd b, mem_error}
  function automatic logic [12:0] m_expect();
    logic [4:0] en;
    logic [2:0] fl;
    if (reset) return 13'b00000_111_00_00_0;
    en = 5'b11111;
    fl = 3'b000;
    if (m_abort) fl = 3'b001;
    else if (m_frozen()) begin
      en = 5'b00001;
      fl = 3'b001;
    end else if (branch_taken) fl = 3'b110;
    else if (idex_MemRead && idex_rd != 0 && (idex_rd == id_rs1 || idex_rd == id_rs2)) begin
      en = 5'b00111;
      fl = 3'b010;
    end
    return {en, fl, m_fwd(ex_rs1), m_fwd(ex_rs2), m_err};
  endfunction

  // Compare every cycle, then advance the model across the coming rising edge.
  always @(negedge clk) begin
    check("outputs", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                      memwb_flush, forward_a, forward_b, mem_error}, m_expect());
    if (reset) begin
      m_waits = 0;
      m_abort = 1'b0;
      m_err   = 1'b0;
    end else if (m_abort) begin
      m_abort = 1'b0;
      m_err   = 1'b1;
      m_waits = 0;
    end else if (m_frozen()) begin
      m_waits++;
      if (m_waits == MemTimeout) begin
        m_abort = 1'b1;
        m_waits = 0;
      end
    end else begin
      m_waits = 0;
    end
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; idex_rd = 0; idex_MemRead = 0; ex_rs1 = 0; ex_rs2 = 0;
    exmem_rd = 0; exmem_RegWrite = 0; memwb_rd = 0; memwb_RegWrite = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int frozen_cnt;

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) next_cycle();
    reset = 1'b0;
    next_cycle();

    // Load-use: exactly one bubble.
    idex_MemRead = 1; idex_rd = 5; id_rs2 = 5;
    @(negedge clk);
    check("loaduse_stall", {pc_en, ifid_en, idex_flush, idex_en}, 4'b0011);
    next_cycle();
    idex_MemRead = 0; idex_rd = 0;
    @(negedge clk);
    check("loaduse_after", {pc_en, ifid_en, idex_flush}, 3'b110);

    // Forwarding priority.
    next_cycle();
    idle();
    exmem_rd = 7; memwb_rd = 7; exmem_RegWrite = 1; memwb_RegWrite = 1; ex_rs1 = 7;
    @(negedge clk);
    check("fwd_exmem", forward_a, 2'b10);
    exmem_rd = 0;
    #1 check("fwd_memwb", forward_a, 2'b01);
    memwb_rd = 0;
    #1 check("fwd_none", forward_a, 2'b00);

    // Asynchronous reset mid-cycle while forwarding would be active.
    next_cycle();
    exmem_rd = 7; ex_rs2 = 7;
    #2 reset = 1'b1;
    #1;
    check("rst_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b0);
    check("rst_flush", {ifid_flush, idex_flush, memwb_flush}, 3'b111);
    check("rst_fwd_err", {forward_a, forward_b, mem_error}, 5'b0);
    next_cycle();
    reset = 1'b0;
    idle();

    // Three cycles of mem_ready low, release on the fourth.
    next_cycle();
    mem_req = 1; mem_ready = 0;
    frozen_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!pc_en && !exmem_en && memwb_en && memwb_flush) frozen_cnt++;
      next_cycle();
    end
    check("memstall_frozen", frozen_cnt, 3);
    mem_ready = 1;
    @(negedge clk);
    check("memstall_release", {pc_en, exmem_en, memwb_flush}, 3'b110);
    next_cycle();
    idle();

    // Timeout: MemTimeout frozen cycles, one abort cycle, then sticky error.
    next_cycle();
    mem_req = 1; mem_ready = 0;
    frozen_cnt = 0;
    for (int i = 0; i < int'(MemTimeout); i++) begin
      @(negedge clk);
      if (!pc_en) frozen_cnt++;
      next_cycle();
    end
    check("tmo_frozen", frozen_cnt, MemTimeout);
    mem_req = 0;
    @(negedge clk);
    check("tmo_abort", {pc_en, exmem_en, memwb_flush, mem_error}, 4'b1110);
    next_cycle();
    @(negedge clk);
    check("tmo_error", {mem_error, pc_en}, 2'b11);
    repeat (3) next_cycle();
    check("tmo_sticky", mem_error, 1'b1);

    // Branch beats load-use.
    idex_MemRead = 1; idex_rd = 9; id_rs1 = 9; branch_taken = 1;
    @(negedge clk);
    check("branch_wins", {ifid_flush, idex_flush, pc_en, ifid_en}, 4'b1111);
    next_cycle();
    idle();

    // Reset in the middle of a wait drops the wait and the error.
    mem_req = 1;
    repeat (3) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    mem_req = 0;
    @(negedge clk);
    check("rst_in_wait", {pc_en, memwb_flush, mem_error}, 3'b100);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      reset          = ($urandom_range(0, 599) == 0);
      id_rs1         = 5'($urandom_range(0, 7));
      id_rs2         = 5'($urandom_range(0, 7));
      idex_rd        = 5'($urandom_range(0, 7));
      idex_MemRead   = ($urandom_range(0, 2) == 0);
      ex_rs1         = 5'($urandom_range(0, 7));
      ex_rs2         = 5'($urandom_range(0, 7));
      exmem_rd       = 5'($urandom_range(0, 7));
      exmem_RegWrite = 1'($urandom);
      memwb_rd       = 5'($urandom_range(0, 7));
      memwb_RegWrite = 1'($urandom);
      branch_taken   = ($urandom_range(0, 5) == 0);
      mem_req        = ($urandom_range(0, 3) == 0);
      mem_ready      = (i % 400 > 360) ? 1'b0 : ($urandom_range(0, 9) < 7);
    end
    next_cycle();
    idle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
